// File: rtl/pad_ring_bist_pkg.sv
// Shared types and helpers for the pad-ring loopback BIST sequencer.
package pad_ring_bist_pkg;

    localparam int unsigned SETTLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Number of pattern steps: walking-one only, or walking-one plus walking-zero.
    function automatic int unsigned steps(input int unsigned n, input logic walk0);
        return walk0 ? 2 * n : n;
    endfunction

endpackage

// File: rtl/pad_ring_bist_if.sv
// Control/status and pad-side signals of the pad-ring BIST, grouped with directional modports.
interface pad_ring_bist_if #(
    parameter int unsigned N_PADS = 8
);
    logic              start;
    logic              abort;
    logic              walk0_en;
    logic [N_PADS-1:0] pad_mask;
    logic [N_PADS-1:0] pad_in;
    logic [N_PADS-1:0] pad_oe;
    logic [N_PADS-1:0] pad_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_PADS-1:0] fail_mask;

    modport master (
        output start, abort, walk0_en, pad_mask, pad_in,
        input  pad_oe, pad_out, busy, done, pass, fail_mask
    );

    modport slave (
        input  start, abort, walk0_en, pad_mask, pad_in,
        output pad_oe, pad_out, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/pad_ring_bist_pattern.sv
// Step-to-pattern generator (onehot, then inverted onehot) and per-pad mismatch reduction.
module pad_ring_bist_pattern
    import pad_ring_bist_pkg::*;
#(
    parameter int unsigned N_PADS = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic [STEP_W-1:0] step_i,
    input  logic [N_PADS-1:0] pad_in_i,
    input  logic [N_PADS-1:0] drive_i,
    input  logic [N_PADS-1:0] mask_i,
    output logic [N_PADS-1:0] pattern_o,
    output logic [N_PADS-1:0] miss_o
);
    logic              phase;
    logic [STEP_W-1:0] idx;
    logic [N_PADS-1:0] onehot;

    always_comb begin
        phase     = (step_i >= STEP_W'(N_PADS));
        idx       = phase ? (step_i - STEP_W'(N_PADS)) : step_i;
        onehot    = {{(N_PADS-1){1'b0}}, 1'b1} << idx;
        pattern_o = phase ? ~onehot : onehot;
    end

    // drive_i is already masked, so XOR against it equals XOR against the raw pattern on masked pads.
    assign miss_o = (pad_in_i ^ drive_i) & mask_i;

endmodule

// File: rtl/pad_ring_bist.sv
// Pad-ring loopback BIST: walks one/zero patterns through the pads and collects a sticky fail mask.
module pad_ring_bist
    import pad_ring_bist_pkg::*;
#(
    parameter int unsigned N_PADS     = 8,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    pad_ring_bist_if.slave  bus
);
    localparam int unsigned STEP_W = $clog2(2 * N_PADS);

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_d;
    logic [STEP_W-1:0]   last_step;
    logic [SETTLE_W-1:0] cnt_q;
    logic                walk0_q;
    logic [N_PADS-1:0]   mask_q;
    logic [N_PADS-1:0]   mask_d;
    logic [N_PADS-1:0]   pattern;
    logic [N_PADS-1:0]   miss;
    logic [N_PADS-1:0]   pad_oe_q;
    logic [N_PADS-1:0]   pad_out_q;
    logic [N_PADS-1:0]   fail_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    // Step and mask that apply on the next entry into DRIVE (from IDLE or from SAMPLE).
    assign step_d    = (state_q == ST_SAMPLE) ? (step_q + STEP_W'(1)) : '0;
    assign mask_d    = (state_q == ST_IDLE) ? bus.pad_mask : mask_q;
    assign last_step = STEP_W'(steps(N_PADS, walk0_q) - 1);

    pad_ring_bist_pattern #(
        .N_PADS (N_PADS),
        .STEP_W (STEP_W)
    ) u_pattern (
        .step_i    (step_d),
        .pad_in_i  (bus.pad_in),
        .drive_i   (pad_out_q),
        .mask_i    (mask_q),
        .pattern_o (pattern),
        .miss_o    (miss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            cnt_q     <= '0;
            walk0_q   <= 1'b0;
            mask_q    <= '0;
            pad_oe_q  <= '0;
            pad_out_q <= '0;
            fail_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else if (bus.abort) begin
            state_q   <= ST_IDLE;
            pad_oe_q  <= '0;
            pad_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_DRIVE;
                        walk0_q   <= bus.walk0_en;
                        mask_q    <= bus.pad_mask;
                        fail_q    <= '0;
                        step_q    <= '0;
                        pad_oe_q  <= bus.pad_mask;
                        pad_out_q <= pattern & mask_d;
                        busy_q    <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    state_q <= ST_SETTLE;
                    cnt_q   <= '0;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + SETTLE_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    fail_q <= fail_q | miss;
                    if (step_q == last_step) begin
                        state_q   <= ST_DONE;
                        pad_oe_q  <= '0;
                        pad_out_q <= '0;
                        done_q    <= 1'b1;
                        pass_q    <= ((fail_q | miss) == '0);
                    end else begin
                        state_q   <= ST_DRIVE;
                        step_q    <= step_d;
                        pad_out_q <= pattern & mask_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pad_oe_q  <= '0;
                    pad_out_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pad_oe    = pad_oe_q;
    assign bus.pad_out   = pad_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;

endmodule
